// File: rtl/dense_input_flattener_pkg.sv
// Shared 16-bit Q5.10 sample format and dense-layer input length.
// Used by the flatten stage and its dense-layer consumer.
package data16_10;
  localparam int WIDTH         = 16;
  localparam int NFRAC         = 10;
  localparam int DENSE_IN_SIZE = 128;

  typedef logic signed [15:0] sample_t;
endpackage

// File: rtl/dense_input_flattener_bank.sv
// One frame buffer: INPUT_SIZE sample registers plus a full flag.
// Latency: one cycle (write and flag updates land on the next clock edge). No internal backpressure.
module flatten_bank #(
  parameter int WIDTH      = 16,
  parameter int INPUT_SIZE = 128,
  parameter int IW         = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    set_full,
  input  logic                    clr_full,
  output logic                    full,
  output logic signed [WIDTH-1:0] data [INPUT_SIZE]
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        data[i] <= '0;
      end
      full <= 1'b0;
    end else begin
      if (wr_en) begin
        data[wr_idx] <= wr_data;
      end
      if (set_full) begin
        full <= 1'b1;
      end else if (clr_full) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dense_input_flattener.sv
// Serial-to-parallel double buffer feeding the dense layer; optional ReLU on write via FLATTEN_RELU_EN.
// Latency: final sample accepted at t gives out_valid at t+1. Backpressure: in_ready drops while the write bank is full.
module dense_input_flattener
  import data16_10::*;
#(
  parameter int WIDTH      = data16_10::WIDTH,
  parameter int NFRAC      = data16_10::NFRAC,
  parameter int INPUT_SIZE = DENSE_IN_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data [INPUT_SIZE],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_frame
);

  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  if (NFRAC >= WIDTH) begin : g_bad_nfrac
    $error("NFRAC must be smaller than WIDTH");
  end

  logic [IW-1:0]           wr_idx;
  logic                    wr_bank;
  logic                    rd_bank;
  logic                    full0;
  logic                    full1;
  logic signed [WIDTH-1:0] wdata;
  logic signed [WIDTH-1:0] data0 [INPUT_SIZE];
  logic signed [WIDTH-1:0] data1 [INPUT_SIZE];

  logic accept;
  logic last_slot;
  logic complete;
  logic consume;

  // Ready and valid come straight from flag registers, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = wr_bank ? !full1 : !full0;
  assign out_valid = rd_bank ? full1 : full0;

  assign accept    = in_valid && in_ready;
  assign last_slot = (wr_idx == IW'(INPUT_SIZE - 1));
  assign complete  = accept && last_slot;
  assign consume   = out_valid && out_ready;

`ifdef FLATTEN_RELU_EN
  assign wdata = in_data[WIDTH-1] ? '0 : in_data;
`else
  assign wdata = in_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (accept) begin
        if (last_slot) begin
          // A missing in_last still completes the frame but is flagged.
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
          if (!in_last) begin
            err_frame <= 1'b1;
          end
        end else if (in_last) begin
          wr_idx    <= '0;
          err_frame <= 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (consume) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  flatten_bank #(
    .WIDTH      (WIDTH),
    .INPUT_SIZE (INPUT_SIZE),
    .IW         (IW)
  ) u_bank0 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && !wr_bank),
    .wr_idx   (wr_idx),
    .wr_data  (wdata),
    .set_full (complete && !wr_bank),
    .clr_full (consume && !rd_bank),
    .full     (full0),
    .data     (data0)
  );

  flatten_bank #(
    .WIDTH      (WIDTH),
    .INPUT_SIZE (INPUT_SIZE),
    .IW         (IW)
  ) u_bank1 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && wr_bank),
    .wr_idx   (wr_idx),
    .wr_data  (wdata),
    .set_full (complete && wr_bank),
    .clr_full (consume && rd_bank),
    .full     (full1),
    .data     (data1)
  );

  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      out_data[i] = rd_bank ? data1[i] : data0[i];
    end
  end

endmodule

// File: tb/tb_dense_input_flattener.sv
// Directed bench for dense_input_flattener; expected values follow FLATTEN_RELU_EN when defined.
// Inputs change and outputs are sampled on the falling edge.
module tb_dense_input_flattener;
  localparam int N = 128;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic signed [15:0]       in_data = '0;
  logic                     in_valid = 1'b0;
  logic                     in_last = 1'b0;
  logic                     in_ready;
  logic signed [15:0]       out_data [N];
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     err_frame;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] fr [N];

  always #5 clk = ~clk;

  dense_input_flattener dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_frame (err_frame)
  );

  function automatic logic signed [15:0] relu(input logic signed [15:0] x);
`ifdef FLATTEN_RELU_EN
    return (x < 0) ? 16'sd0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int k = 0; k < N; k++) fr[k] = 16'(base + k);
  endtask

  // Drives fr[0..n-1] one per cycle; returns on the falling edge after the last accept.
  task automatic push_frame(input int n, input bit with_last);
    int guard;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = fr[k];
      in_last  = with_last && (k == n - 1);
      guard = 0;
      while (!in_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad = 0;
    logic signed [15:0] e;
    for (int k = 0; k < N; k++) begin
      e = relu(16'(base + k));
      if (out_data[k] !== e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic pulse_consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int nz;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_err_frame", {31'd0, err_frame}, 0);
    nz = 0;
    for (int k = 0; k < N; k++) if (out_data[k] !== 16'sd0) nz++;
    chk("rst_out_data_zero", nz, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single frame, consumer always ready
    fill_ramp(0);
    out_ready = 1'b1;
    push_frame(N, 1'b1);
    chk("t1_out_valid_latency", {31'd0, out_valid}, 1);
    check_frame("t1_frame_ramp", 0);
    chk("t1_last_elem", out_data[N-1], 127);
    chk("t1_err_frame", {31'd0, err_frame}, 0);
    @(negedge clk);
    chk("t1_out_valid_drop", {31'd0, out_valid}, 0);
    out_ready = 1'b0;

    // Three frames against a stalled consumer
    fill_ramp(1000);
    push_frame(N, 1'b1);
    fill_ramp(2000);
    push_frame(N, 1'b1);
    chk("t2_both_full_in_ready", {31'd0, in_ready}, 0);
    chk("t2_out_valid", {31'd0, out_valid}, 1);
    fill_ramp(3000);
    in_valid = 1'b1;
    in_data  = fr[0];
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_stall_in_ready", {31'd0, in_ready}, 0);
    check_frame("t2_frame_a_held", 1000);
    pulse_consume();
    chk("t2_freed_in_ready", {31'd0, in_ready}, 1);
    check_frame("t2_frame_b", 2000);
    push_frame(N, 1'b1);
    check_frame("t2_frame_b_stable", 2000);
    chk("t2_refull_in_ready", {31'd0, in_ready}, 0);
    pulse_consume();
    chk("t2_frame_c_valid", {31'd0, out_valid}, 1);
    check_frame("t2_frame_c", 3000);
    pulse_consume();
    chk("t2_drained", {31'd0, out_valid}, 0);

    // Early in_last on sample 50
    fill_ramp(0);
    push_frame(51, 1'b1);
    chk("t3_err_early_last", {31'd0, err_frame}, 1);
    chk("t3_no_out_valid", {31'd0, out_valid}, 0);
    fill_ramp(500);
    push_frame(N, 1'b1);
    chk("t3_next_valid", {31'd0, out_valid}, 1);
    chk("t3_next_elem0", out_data[0], 500);
    check_frame("t3_next_frame", 500);
    pulse_consume();
    reset = 1'b1;
    #1;
    chk("t3_reset_clears_err", {31'd0, err_frame}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Missing in_last
    fill_ramp(600);
    push_frame(N, 1'b0);
    chk("t4_valid", {31'd0, out_valid}, 1);
    check_frame("t4_frame", 600);
    chk("t4_err_missing_last", {31'd0, err_frame}, 1);
    pulse_consume();
    fill_ramp(700);
    push_frame(N, 1'b1);
    check_frame("t4_good_frame", 700);
    chk("t4_err_sticky", {31'd0, err_frame}, 1);
    pulse_consume();

    // Mixed-sign samples
    fill_ramp(0);
    fr[0] = -16'sd1024;
    fr[1] = 16'sd0;
    fr[2] = 16'sd1023;
    fr[3] = -16'sd1;
    push_frame(N, 1'b1);
`ifdef FLATTEN_RELU_EN
    chk("t5_elem0", out_data[0], 0);
    chk("t5_elem1", out_data[1], 0);
    chk("t5_elem2", out_data[2], 1023);
    chk("t5_elem3", out_data[3], 0);
`else
    chk("t5_elem0", out_data[0], -1024);
    chk("t5_elem1", out_data[1], 0);
    chk("t5_elem2", out_data[2], 1023);
    chk("t5_elem3", out_data[3], -1);
`endif
    chk("t5_elem4", out_data[4], 4);
    pulse_consume();

    // Reset mid-frame with a frame pending
    fill_ramp(800);
    push_frame(N, 1'b1);
    fill_ramp(900);
    push_frame(70, 1'b0);
    chk("t6_pending_valid", {31'd0, out_valid}, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_out_valid", {31'd0, out_valid}, 0);
    chk("t6_async_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fill_ramp(950);
    push_frame(N, 1'b1);
    chk("t6_fresh_valid", {31'd0, out_valid}, 1);
    chk("t6_fresh_elem0", out_data[0], 950);
    check_frame("t6_fresh_frame", 950);
    pulse_consume();
    chk("t6_fresh_consumed", {31'd0, out_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
